// File: rtl/dft64_frame_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dft64_frame_loader
//
// Upstream feeder for dft64. Serial signed samples arrive on a valid/ready
// handshake and are collected into one of two frame banks (ping-pong). Each
// completed frame is sent to dft64 as BEATS back-to-back beats of LANES
// samples. After a burst, the block waits for dft64 `done` before it starts the
// next burst. While that frame is being transformed, the other bank keeps
// filling.
//
// Ports
//   clk           sole clock, rising edge
//   sreset        asynchronous, active-high reset (release is synchronous)
//   sample_in     input sample, two's complement, SAMPLE_W bits
//   sample_valid  sample_in is valid
//   sample_ready  a sample can be accepted this cycle (0 while both banks are
//                 full or while sreset is high)
//   samples       beat data {s[L*b], s[L*b+1], ..., s[L*b+L-1]}, with the
//                 lowest-index sample in the MSBs
//   rel           samples valid; high for exactly BEATS consecutive cycles
//   calculate     high while a frame is being delivered or transformed
//   done          dft64 result-valid; only looked at in WAIT_DONE
//   frames_sent   count of completed bursts, wraps at 16 bits
//   timeout_err   sticky; set when done does not arrive within DONE_TIMEOUT
//
// FRAME must be a multiple of LANES.
// -----------------------------------------------------------------------------
module dft64_frame_loader #(
  parameter int SAMPLE_W     = 16,
  parameter int LANES        = 8,
  parameter int FRAME        = 64,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic [SAMPLE_W-1:0]       sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic [LANES*SAMPLE_W-1:0] samples,
  output logic                      rel,
  output logic                      calculate,
  input  logic                      done,
  output logic [15:0]               frames_sent,
  output logic                      timeout_err
);

  localparam int BEATS  = FRAME / LANES;
  localparam int IDX_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    WAIT_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and bank bookkeeping
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] mem [2][FRAME];
  logic [1:0]          full;
  logic [1:0]          full_d;
  logic                wr_bank;
  logic                rd_bank;
  logic [IDX_W-1:0]    wr_idx;
  logic                accept;
  logic                wr_last;

  // Read FSM
  state_t              state_q;
  state_t              state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                release_bank;
  logic                timeout_hit;

  // Next values of the registered outputs
  logic                      rel_d;
  logic                      calc_d;
  logic [LANES*SAMPLE_W-1:0] samples_d;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // Ready depends only on registered flags and on reset. It never depends on
  // sample_valid, so the handshake has no combinational loop.
  assign sample_ready = ~full[wr_bank] & ~sreset;
  assign accept       = sample_valid & sample_ready;
  assign wr_last      = (wr_idx == IDX_W'(FRAME - 1));

  // NOTE: the sample store has no reset. Its contents are meaningless until
  // the matching full flag is set, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_idx] <= sample_in;
    end
  end

  // The writer may complete one bank on the same edge that the reader
  // releases the other. Both updates are merged here. They can never target
  // the same bank, because a full bank blocks writes.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so later conditional overrides cannot infer a latch.
    full_d = full;
    if (release_bank) begin
      full_d[rd_bank] = 1'b0;
    end
    if (accept && wr_last) begin
      full_d[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge sreset) begin
    // NOTE: clocked state uses non-blocking '<=', so every flop samples values
    // from before the edge, whatever order the statements appear in.
    if (sreset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      full <= full_d;
      if (accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next state
  // beat_q is the index of the beat currently on `samples`.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    release_bank = 1'b0;
    timeout_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full[rd_bank]) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d      = WAIT_DONE;
          cnt_d        = '0;
          release_bank = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // done wins over a timeout that expires on the same edge.
        if (done) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM: outputs
  // The outputs are decoded from the next state and registered below, so rel
  // and samples change together on the edge where the beat is launched.
  // ---------------------------------------------------------------------------
  always_comb begin
    rel_d     = (state_d == BURST);
    calc_d    = (state_d != IDLE);
    samples_d = samples;
    if (state_d == BURST) begin
      for (int k = 0; k < LANES; k++) begin
        samples_d[(LANES-1-k)*SAMPLE_W +: SAMPLE_W] =
          mem[rd_bank][IDX_W'(int'(beat_d) * LANES + k)];
      end
    end
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      rel         <= 1'b0;
      calculate   <= 1'b0;
      samples     <= '0;
      rd_bank     <= 1'b0;
      frames_sent <= '0;
      timeout_err <= 1'b0;
    end else begin
      rel       <= rel_d;
      calculate <= calc_d;
      samples   <= samples_d;
      if (release_bank) begin
        rd_bank     <= ~rd_bank;
        frames_sent <= frames_sent + 16'd1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dft64_frame_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dft64_frame_loader
//
// Randomised self-checking bench for dft64_frame_loader. A frame-level
// reference model tracks:
//   - the samples accepted so far, grouped into completed frames
//   - when each frame completed, and when the reader is next free
//   - the done-wait window
// From these it predicts every cycle's rel, beat data, calculate,
// frames_sent, timeout_err and sample_ready.
// -----------------------------------------------------------------------------
module tb_dft64_frame_loader;

  localparam int SAMPLE_W     = 16;
  localparam int LANES        = 8;
  localparam int FRAME        = 64;
  localparam int DONE_TIMEOUT = 16;
  localparam int BEATS        = FRAME / LANES;
  localparam int W            = LANES * SAMPLE_W;

  logic                clk = 1'b0;
  logic                sreset;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic [W-1:0]        samples;
  logic                rel;
  logic                calculate;
  logic                done;
  logic [15:0]         frames_sent;
  logic                timeout_err;

  always #5 clk = ~clk;

  dft64_frame_loader #(
    .SAMPLE_W     (SAMPLE_W),
    .LANES        (LANES),
    .FRAME        (FRAME),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk          (clk),
    .sreset       (sreset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .samples      (samples),
    .rel          (rel),
    .calculate    (calculate),
    .done         (done),
    .frames_sent  (frames_sent),
    .timeout_err  (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] stim_q[$];     // samples still to offer
  logic [SAMPLE_W-1:0] cur_frame[$];  // accepted, frame not yet complete
  logic [SAMPLE_W-1:0] exp_q[$];      // completed frames awaiting delivery
  int                  comp_q[$];     // cycle each pending frame completed
  int                  cyc;
  int                  wc, rc;        // frames written / released
  int                  beat;          // beats of the current burst seen so far
  int                  idle_edge;     // cycle the reader last became free
  int                  wait_age;
  int                  done_timer;
  int                  done_delay;    // -1 never, -2 random 0..10
  int                  valid_pct;
  int                  spur_pct;      // done pulses while not waiting
  int                  n_acc;
  bit                  in_wait;
  bit                  exp_to;
  bit                  acc_prev;
  bit                  done_prev;
  bit                  got_first;
  logic [SAMPLE_W-1:0] drv_sample;
  logic [15:0]         sent;
  logic [W-1:0]        last_beat;
  logic [W-1:0]        first_beat;

  function automatic logic [W-1:0] beat_word(input int b);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[(LANES-1-k)*SAMPLE_W +: SAMPLE_W] = exp_q[b*LANES + k];
    return w;
  endfunction

  // One clock cycle: observe at the falling edge, update the model, compare,
  // then drive the next inputs.
  task automatic step();
    bit exp_rel;
    int start;
    @(negedge clk);
    cyc++;

    if (acc_prev) begin
      cur_frame.push_back(drv_sample);
      n_acc++;
      if (cur_frame.size() == FRAME) begin
        foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
        cur_frame.delete();
        comp_q.push_back(cyc);
        wc++;
      end
    end

    if (in_wait) begin
      wait_age++;
      if (done_prev) begin
        in_wait   = 1'b0;
        idle_edge = cyc;
      end else if (wait_age == DONE_TIMEOUT) begin
        in_wait   = 1'b0;
        idle_edge = cyc;
        exp_to    = 1'b1;
      end
    end

    exp_rel = 1'b0;
    if (beat > 0 && beat < BEATS) begin
      exp_rel = 1'b1;
    end else if (beat == 0 && !in_wait && comp_q.size() > 0) begin
      start   = ((idle_edge > comp_q[0]) ? idle_edge : comp_q[0]) + 1;
      exp_rel = (cyc >= start);
    end

    check("rel", rel, exp_rel);
    if (exp_rel) begin
      if (beat == 0 && !got_first) begin
        first_beat = samples;
        got_first  = 1'b1;
      end
      check("beat_data", samples, beat_word(beat));
      last_beat = beat_word(beat);
      beat++;
    end else if (beat == BEATS) begin
      repeat (FRAME) void'(exp_q.pop_front());
      void'(comp_q.pop_front());
      rc++;
      sent++;
      beat       = 0;
      in_wait    = 1'b1;
      wait_age   = 0;
      done_timer = (done_delay == -2) ? int'($urandom_range(10)) : done_delay;
    end

    check("calculate", calculate, exp_rel || in_wait);
    if (in_wait) check("samples_hold", samples, last_beat);
    check("frames_sent", frames_sent, sent);
    check("timeout_err", timeout_err, exp_to);
    check("sample_ready", sample_ready, (wc - rc) < 2);

    done_prev = 1'b0;
    if (done_timer == 0) done_prev = 1'b1;
    else if (!in_wait && spur_pct > 0 && $urandom_range(99) < spur_pct) done_prev = 1'b1;
    if (done_timer >= 0) done_timer--;
    done = done_prev;

    if (stim_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      sample_valid = 1'b1;
      drv_sample   = stim_q[0];
      sample_in    = drv_sample;
    end else begin
      sample_valid = 1'b0;
      sample_in    = SAMPLE_W'($urandom);
    end
    acc_prev = sample_valid && sample_ready;
    if (acc_prev) void'(stim_q.pop_front());
  endtask

  task automatic do_reset();
    sreset       = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    done         = 1'b0;
    repeat (3) @(negedge clk);
    stim_q.delete();
    cur_frame.delete();
    exp_q.delete();
    comp_q.delete();
    wc = 0; rc = 0; beat = 0; wait_age = 0; n_acc = 0;
    in_wait = 1'b0; exp_to = 1'b0; acc_prev = 1'b0; done_prev = 1'b0; got_first = 1'b0;
    done_timer = -1; sent = '0; last_beat = '0; spur_pct = 0; valid_pct = 100;
    check("reset_rel", rel, 1'b0);
    check("reset_calculate", calculate, 1'b0);
    check("reset_samples", samples, '0);
    check("reset_frames_sent", frames_sent, 16'd0);
    check("reset_timeout_err", timeout_err, 1'b0);
    check("reset_sample_ready", sample_ready, 1'b0);
    sreset    = 1'b0;
    idle_edge = cyc;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || cur_frame.size() > 0 || exp_q.size() > 0 || in_wait || beat != 0)
           && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, n < budget, 1'b1);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(SAMPLE_W'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ramp_b0;
    int           n_wait;

    sreset = 1'b1; sample_valid = 1'b0; sample_in = '0; done = 1'b0;
    cyc = 0; done_delay = 0; valid_pct = 100; spur_pct = 0;

    // 1 kHz sine at 48 kHz, done three cycles after the last beat
    do_reset();
    for (int n = 0; n < FRAME; n++)
      stim_q.push_back(SAMPLE_W'($rtoi($sin(2.0 * 3.14159265358979 * 1000.0 * n / 48000.0) * 256.0)));
    done_delay = 2;
    drain("sine", 400);
    check("sine_frames_sent", frames_sent, 16'd1);
    check("sine_timeout_err", timeout_err, 1'b0);

    // Ramp: beat b lane k must carry 8b+k
    do_reset();
    for (int n = 0; n < FRAME; n++) stim_q.push_back(SAMPLE_W'(n));
    done_delay = 0;
    drain("ramp", 400);
    ramp_b0 = '0;
    for (int k = 0; k < LANES; k++) ramp_b0[(LANES-1-k)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(k);
    check("ramp_beat0", first_beat, ramp_b0);

    // Continuous offer of three frames, done never arrives
    do_reset();
    push_random(3 * FRAME);
    done_delay = -1;
    drain("backpressure", 3000);
    check("bp_accepted", n_acc, 3 * FRAME);
    check("bp_timeout_err", timeout_err, 1'b1);
    check("bp_frames_sent", frames_sent, 16'd3);

    // done on the last allowed edge counts; one edge later times out
    do_reset();
    push_random(FRAME);
    done_delay = DONE_TIMEOUT - 1;
    drain("to_edge", 400);
    check("to_edge_no_err", timeout_err, 1'b0);
    push_random(FRAME);
    done_delay = DONE_TIMEOUT;
    drain("to_late", 400);
    check("to_late_err", timeout_err, 1'b1);

    // Second frame streams while the first is transformed
    do_reset();
    push_random(2 * FRAME);
    done_delay = 5;
    drain("overlap", 800);
    check("overlap_frames_sent", frames_sent, 16'd2);

    // Reset in the middle of a burst
    do_reset();
    push_random(FRAME);
    done_delay = 0;
    drain("pre_rst", 400);
    push_random(FRAME);
    n_wait = 0;
    while (beat != 4 && n_wait < 400) begin
      step();
      n_wait++;
    end
    check("mid_burst_reached", n_wait < 400, 1'b1);
    sreset = 1'b1;
    #1;
    check("rst_rel", rel, 1'b0);
    check("rst_calculate", calculate, 1'b0);
    check("rst_frames_sent", frames_sent, 16'd0);
    check("rst_sample_ready", sample_ready, 1'b0);
    check("rst_samples", samples, '0);
    do_reset();
    push_random(FRAME);
    done_delay = 0;
    drain("post_rst", 400);
    check("post_rst_frames_sent", frames_sent, 16'd1);

    // Random valid gaps over ten frames, prompt done, stray done pulses
    do_reset();
    push_random(10 * FRAME);
    valid_pct  = 50;
    spur_pct   = 10;
    done_delay = -2;
    drain("random", 8000);
    check("rand_accepted", n_acc, 10 * FRAME);
    check("rand_frames_sent", frames_sent, 16'd10);
    check("rand_timeout_err", timeout_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
